// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: sweeps the enabled ALU ops 0..9, holds each select code for SETTLE
// cycles, then captures the ALU result into a per-op register for combinational readback.
// Optional feature: define ALU_SEQ_ZERO_FLAG_EN to add the per-op zero_flags output.
module alu_op_sequencer #(
   parameter int unsigned N      = 4,
   parameter int unsigned SETTLE = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [9:0]   op_mask,
   input  logic [N-1:0] alu_out,
   output logic [3:0]   select,
   output logic         capture,
   output logic         busy,
   output logic         done,
   input  logic [3:0]   rd_sel,
   output logic [N-1:0] rd_data,
   output logic         rd_valid
`ifdef ALU_SEQ_ZERO_FLAG_EN
   ,
   output logic [9:0]   zero_flags
`endif
);

   localparam logic [3:0] SettleLast = 4'(SETTLE - 1);

   typedef enum logic [1:0] {StIdle, StIssue, StFinish} state_e;

   state_e         state_q;
   logic [3:0]     select_q;
   logic [9:0]     mask_q;
   logic [3:0]     cnt_q;
   logic [N-1:0]   res_q [10];
   logic [9:0]     valid_q;
   logic           busy_q;
   logic           done_q;
`ifdef ALU_SEQ_ZERO_FLAG_EN
   logic [9:0]     zf_q;
`endif

   logic [3:0]     first_op;
   logic [3:0]     next_op;
   logic           next_found;
   logic           cap_now;

   // Lowest set bit of the incoming mask, and lowest latched-mask bit above the current op.
   always_comb begin
      first_op   = '0;
      next_op    = '0;
      next_found = 1'b0;
      // Scan downward so the lowest qualifying index is the last one written.
      for (int i = 9; i >= 0; i--) begin
         if (op_mask[i]) begin
            first_op = 4'(i);
         end
         if (mask_q[i] && (4'(i) > select_q)) begin
            next_op    = 4'(i);
            next_found = 1'b1;
         end
      end
   end

   assign cap_now = (state_q == StIssue) && (cnt_q == SettleLast);

   // Sweep FSM with registered select/busy/done and the per-op result store.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         select_q <= '0;
         mask_q   <= '0;
         cnt_q    <= '0;
         valid_q  <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         for (int i = 0; i < 10; i++) begin
            res_q[i] <= '0;
         end
`ifdef ALU_SEQ_ZERO_FLAG_EN
         zf_q     <= '0;
`endif
      end else begin
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  valid_q <= '0;
`ifdef ALU_SEQ_ZERO_FLAG_EN
                  zf_q    <= '0;
`endif
                  if (|op_mask) begin
                     mask_q   <= op_mask;
                     select_q <= first_op;
                     cnt_q    <= '0;
                     busy_q   <= 1'b1;
                     state_q  <= StIssue;
                  end else begin
                     done_q  <= 1'b1;
                     state_q <= StFinish;
                  end
               end
            end
            StIssue: begin
               if (cap_now) begin
                  for (int i = 0; i < 10; i++) begin
                     if (select_q == 4'(i)) begin
                        res_q[i]   <= alu_out;
                        valid_q[i] <= 1'b1;
`ifdef ALU_SEQ_ZERO_FLAG_EN
                        zf_q[i]    <= (alu_out == '0);
`endif
                     end
                  end
                  cnt_q <= '0;
                  if (next_found) begin
                     select_q <= next_op;
                  end else begin
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= StFinish;
                  end
               end else begin
                  cnt_q <= cnt_q + 4'd1;
               end
            end
            StFinish: begin
               done_q  <= 1'b0;
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   // Combinational readback; indices 10..15 read as empty.
   always_comb begin
      rd_data  = '0;
      rd_valid = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (rd_sel == 4'(i)) begin
            rd_data  = res_q[i];
            rd_valid = valid_q[i];
         end
      end
   end

   assign select  = select_q;
   assign capture = cap_now;
   assign busy    = busy_q;
   assign done    = done_q;
`ifdef ALU_SEQ_ZERO_FLAG_EN
   assign zero_flags = zf_q;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer: two instances (SETTLE=1 and SETTLE=3).
module tb_alu_op_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start_a = 1'b0;
   logic       start_b = 1'b0;
   logic [9:0] op_mask = '0;
   logic [3:0] rd_sel = '0;
   logic       stub_zero = 1'b0;

   logic [3:0] alu_a, alu_b, sel_a, sel_b, rd_data_a, rd_data_b;
   logic       cap_a, cap_b, busy_a, busy_b, done_a, done_b, rd_valid_a, rd_valid_b;
`ifdef ALU_SEQ_ZERO_FLAG_EN
   logic [9:0] zf_a, zf_b;
`endif

   int n_tests = 0;
   int n_fail  = 0;
   int cap_cnt_a = 0;
   int cap_cnt_b = 0;
   logic [3:0] qa[$];
   logic [3:0] qb[$];

   always #5 clk = ~clk;

   // ALU stubs
   assign alu_a = stub_zero ? ((sel_a == 4'd2) ? 4'd0 : 4'd5) : sel_a + 4'd1;
   assign alu_b = sel_b + 4'd1;

   alu_op_sequencer #(.N(4), .SETTLE(1)) dut_a (
      .clk(clk), .rst(rst), .start(start_a), .op_mask(op_mask), .alu_out(alu_a),
      .select(sel_a), .capture(cap_a), .busy(busy_a), .done(done_a),
      .rd_sel(rd_sel), .rd_data(rd_data_a), .rd_valid(rd_valid_a)
`ifdef ALU_SEQ_ZERO_FLAG_EN
      , .zero_flags(zf_a)
`endif
   );

   alu_op_sequencer #(.N(4), .SETTLE(3)) dut_b (
      .clk(clk), .rst(rst), .start(start_b), .op_mask(op_mask), .alu_out(alu_b),
      .select(sel_b), .capture(cap_b), .busy(busy_b), .done(done_b),
      .rd_sel(rd_sel), .rd_data(rd_data_b), .rd_valid(rd_valid_b)
`ifdef ALU_SEQ_ZERO_FLAG_EN
      , .zero_flags(zf_b)
`endif
   );

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Monitor: every capture pulse pops the expected select code.
   always @(negedge clk) begin
      if (!rst) begin
         if (cap_a) begin
            cap_cnt_a++;
            check("cap_sel_a", int'(sel_a), (qa.size() != 0) ? int'(qa.pop_front()) : 15);
         end
         if (cap_b) begin
            cap_cnt_b++;
            check("cap_sel_b", int'(sel_b), (qb.size() != 0) ? int'(qb.pop_front()) : 15);
         end
      end
   end

   task automatic readback(input int idx, input int exp_data, input int exp_valid);
      rd_sel = 4'(idx);
      #1;
      check($sformatf("rd_data[%0d]", idx), int'(rd_data_a), exp_data);
      check($sformatf("rd_valid[%0d]", idx), int'(rd_valid_a), exp_valid);
   endtask

   // One sweep on instance `which` (0: SETTLE=1, 1: SETTLE=3); poke retries start mid-run.
   task automatic sweep(input int which, input logic [9:0] mask, input bit poke);
      int m = 0;
      int settle = (which != 0) ? 3 : 1;
      int nb = 0;
      int cyc = 0;
      int cap0;
      bit seen = 0;
      bit b, c, d;
      for (int i = 0; i < 10; i++) begin
         if (mask[i]) begin
            m++;
            if (which != 0) qb.push_back(4'(i));
            else qa.push_back(4'(i));
         end
      end
      cap0 = (which != 0) ? cap_cnt_b : cap_cnt_a;
      @(posedge clk); #1;
      op_mask = mask;
      if (which != 0) start_b = 1'b1; else start_a = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0;
      start_b = 1'b0;
      while (!seen && cyc < 200) begin
         @(negedge clk);
         cyc++;
         start_a = 1'b0;
         b = (which != 0) ? busy_b : busy_a;
         c = (which != 0) ? cap_b : cap_a;
         d = (which != 0) ? done_b : done_a;
         if (b) begin
            if (c) check("cap_phase", nb % settle, settle - 1);
            nb++;
            if (poke && nb == 1) begin
               start_a = 1'b1;
               op_mask = 10'h3FF;
            end
         end
         if (d) begin
            seen = 1;
            check("done_busy_low", int'(b), 0);
            if (poke) start_a = 1'b1;
         end
      end
      check("done_seen", int'(seen), 1);
      check("busy_cycles", nb, m * settle);
      @(negedge clk);
      start_a = 1'b0;
      check("done_one_cycle", int'((which != 0) ? done_b : done_a), 0);
      check("capture_count", ((which != 0) ? cap_cnt_b : cap_cnt_a) - cap0, m);
      check("queue_drained", (which != 0) ? qb.size() : qa.size(), 0);
      repeat (2) @(negedge clk);
      check("no_restart", int'((which != 0) ? busy_b : busy_a), 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int busy_seen;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      // Reset state
      check("rst_select", int'(sel_a), 0);
      check("rst_busy", int'(busy_a), 0);
      check("rst_done", int'(done_a), 0);
      check("rst_capture", int'(cap_a), 0);
      for (int i = 0; i < 10; i++) readback(i, 0, 0);

      // 1: full sweep, SETTLE=1
      sweep(0, 10'h3FF, 1'b0);
      for (int i = 0; i < 10; i++) readback(i, i + 1, 1);

      // 2: ops 0 and 9 only; op 3 keeps old data but is invalid
      sweep(0, 10'b10_0000_0001, 1'b0);
      readback(0, 1, 1);
      readback(3, 4, 0);
      readback(9, 10, 1);

      // 3: empty mask
      sweep(0, 10'h000, 1'b0);
      readback(0, 1, 0);
      readback(9, 10, 0);

      // 4: SETTLE=3, ops 1 and 2
      sweep(1, 10'h006, 1'b0);
      rd_sel = 4'd1;
      #1;
      check("b_rd_data1", int'(rd_data_b), 2);
      check("b_rd_valid1", int'(rd_valid_b), 1);

      // 5: reset on the 4th cycle of a full sweep
      qa.push_back(4'd0);
      qa.push_back(4'd1);
      qa.push_back(4'd2);
      @(posedge clk); #1;
      op_mask = 10'h3FF;
      start_a = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("abort_busy", int'(busy_a), 0);
      check("abort_select", int'(sel_a), 0);
      check("abort_done", int'(done_a), 0);
      check("abort_queue", qa.size(), 0);
      for (int i = 0; i < 10; i++) readback(i, 0, 0);
      busy_seen = 0;
      repeat (12) begin
         @(negedge clk);
         if (busy_a || done_a) busy_seen++;
      end
      check("abort_no_resume", busy_seen, 0);

      // Start while busy and during FINISH is ignored
      sweep(0, 10'h003, 1'b1);
      readback(1, 2, 1);
      readback(2, 0, 0);
      readback(12, 0, 0);

`ifdef ALU_SEQ_ZERO_FLAG_EN
      // 6: zero flags
      stub_zero = 1'b1;
      sweep(0, 10'h3FF, 1'b0);
      check("zero_flags", int'(zf_a), 32'h004);
      readback(2, 0, 1);
      readback(5, 5, 1);
      stub_zero = 1'b0;
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
